// File: rtl/stage_ex_pkg.sv
// Shared ALU encodings for decode and execute, plus divider state type.
// Any change to an opcode here changes both stages at once.
package stage_ex_pkg;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'b000,
        SEL_LOGIC = 3'b001,
        SEL_SHIFT = 3'b010,
        SEL_MOVE  = 3'b011,
        SEL_ARITH = 3'b100
    } alusel_e;

    localparam logic [7:0] OP_OR    = 8'h25;
    localparam logic [7:0] OP_AND   = 8'h24;
    localparam logic [7:0] OP_XOR   = 8'h26;
    localparam logic [7:0] OP_NOR   = 8'h27;
    localparam logic [7:0] OP_SLL   = 8'h7C;
    localparam logic [7:0] OP_SRL   = 8'h02;
    localparam logic [7:0] OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_ADDU  = 8'h21;
    localparam logic [7:0] OP_SUBU  = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A;
    localparam logic [7:0] OP_SLTU  = 8'h2B;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/stage_ex_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle on magnitudes,
// signs reapplied on the outputs.
module div_unit
    import stage_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state, state_n;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, den;
    logic        neg_q, neg_r;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh, diff;

    assign a_mag  = neg_if(is_signed && dividend[31], dividend);
    assign b_mag  = neg_if(is_signed && divisor[31], divisor);
    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - {1'b0, den};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            DIV_IDLE: if (start) state_n = (divisor == 32'd0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == 5'd31) state_n = DIV_DONE;
            DIV_DONE: state_n = DIV_IDLE;
            default:  state_n = DIV_IDLE;
        endcase
    end

    // Divide-by-zero preloads the architectural result and skips RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            den   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt <= '0;
            if (divisor == 32'd0) begin
                quo   <= 32'hFFFF_FFFF;
                rem   <= dividend;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                quo   <= a_mag;
                rem   <= '0;
                den   <= b_mag;
                neg_q <= is_signed && (dividend[31] ^ divisor[31]);
                neg_r <= is_signed && dividend[31];
            end
        end else if (state == DIV_RUN) begin
            cnt <= cnt + 5'd1;
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
        end
    end

    assign done      = (state == DIV_DONE);
    assign busy      = (state != DIV_IDLE);
    assign quotient  = neg_if(neg_q, quo);
    assign remainder = neg_if(neg_r, rem);

endmodule

// File: rtl/stage_ex.sv
// Execute stage: single-cycle logic/shift/move/arith/multiply and a
// multi-cycle divider that stalls upstream while it runs.
module stage_ex
    import stage_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  aluop,
    input  logic [2:0]  alusel,
    input  logic [31:0] opv1,
    input  logic [31:0] opv2,
    input  logic        we,
    input  logic [4:0]  waddr,
    output logic        stall_req,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        legal, is_mult, is_div, mul_signed, div_signed;
    logic [31:0] result;
    logic [4:0]  sa;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        accept, div_start, div_done, div_busy;
    logic [31:0] div_q, div_r;

    assign sa     = opv1[4:0];
    assign prod_s = $signed({{32{opv1[31]}}, opv1}) * $signed({{32{opv2[31]}}, opv2});
    assign prod_u = {32'd0, opv1} * {32'd0, opv2};

    always_comb begin
        legal      = 1'b0;
        is_mult    = 1'b0;
        is_div     = 1'b0;
        mul_signed = 1'b0;
        div_signed = 1'b0;
        result     = '0;
        unique case (alusel)
            SEL_LOGIC: begin
                legal = 1'b1;
                unique case (aluop)
                    OP_OR:   result = opv1 | opv2;
                    OP_AND:  result = opv1 & opv2;
                    OP_XOR:  result = opv1 ^ opv2;
                    OP_NOR:  result = ~(opv1 | opv2);
                    default: legal = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                legal = 1'b1;
                unique case (aluop)
                    OP_SLL:  result = opv2 << sa;
                    OP_SRL:  result = opv2 >> sa;
                    OP_SRA:  result = $signed(opv2) >>> sa;
                    default: legal = 1'b0;
                endcase
            end
            SEL_MOVE: begin
                legal = 1'b1;
                unique case (aluop)
                    OP_MFHI: result = hi;
                    OP_MFLO: result = lo;
                    default: legal = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                legal = 1'b1;
                unique case (aluop)
                    OP_ADDU:  result = opv1 + opv2;
                    OP_SUBU:  result = opv1 - opv2;
                    OP_SLT:   result = {31'd0, $signed(opv1) < $signed(opv2)};
                    OP_SLTU:  result = {31'd0, opv1 < opv2};
                    OP_MULT:  begin is_mult = 1'b1; mul_signed = 1'b1; end
                    OP_MULTU: is_mult = 1'b1;
                    OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
                    OP_DIVU:  is_div = 1'b1;
                    default:  legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Gated by rst so the stall drops the moment reset is asserted.
    assign stall_req = rst && in_valid && is_div && !div_done;
    assign accept    = in_valid && !stall_req;
    assign div_start = in_valid && is_div && !div_busy;

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (opv1),
        .divisor   (opv2),
        .done      (div_done),
        .busy      (div_busy),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (accept && legal) begin
            wb_valid <= 1'b1;
            wb_we    <= we && !(is_mult || is_div);
            wb_waddr <= waddr;
            wb_wdata <= result;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= div_r;
            lo <= div_q;
        end else if (accept && is_mult) begin
            {hi, lo} <= mul_signed ? prod_s : prod_u;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// Bench for stage_ex: directed table, hand sequences for multiply/divide/
// reset, and random ops checked against an arithmetic reference model.
module tb_stage_ex;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  aluop = '0;
    logic [2:0]  alusel = '0;
    logic [31:0] opv1 = '0, opv2 = '0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic        stall_req, wb_valid, wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, hi, lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    localparam logic [10:0] CODES [17] = '{
        {3'd1, 8'h25}, {3'd1, 8'h24}, {3'd1, 8'h26}, {3'd1, 8'h27},
        {3'd2, 8'h7C}, {3'd2, 8'h02}, {3'd2, 8'h03},
        {3'd3, 8'h10}, {3'd3, 8'h12},
        {3'd4, 8'h21}, {3'd4, 8'h23}, {3'd4, 8'h2A}, {3'd4, 8'h2B},
        {3'd4, 8'h18}, {3'd4, 8'h19}, {3'd4, 8'h1A}, {3'd4, 8'h1B}
    };

    typedef struct {
        logic        v;
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        w;
        logic [4:0]  wa;
        logic        ev, ewe;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [15];

    stage_ex dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .aluop     (aluop),
        .alusel    (alusel),
        .opv1      (opv1),
        .opv2      (opv2),
        .we        (we),
        .waddr     (waddr),
        .stall_req (stall_req),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic w, input logic [4:0] wa);
        in_valid = v; alusel = s; aluop = o;
        opv1 = a; opv2 = b; we = w; waddr = wa;
    endtask

    function automatic logic legal(input logic [2:0] s, input logic [7:0] o);
        foreach (CODES[i]) if (CODES[i] == {s, o}) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [7:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = a % 32;
        case (o)
            8'h25: return a | b;
            8'h24: return a & b;
            8'h26: return a ^ b;
            8'h27: return ~(a | b);
            8'h7C: return b << sh;
            8'h02: return b >> sh;
            8'h03: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            8'h10: return m_hi;
            8'h12: return m_lo;
            8'h21: return a + b;
            8'h23: return a - b;
            8'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            8'h2B: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic v, input logic [2:0] s, input logic [7:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic w, input logic [4:0] wa);
        logic ok, mul;
        logic [31:0] ed;
        logic [63:0] p;
        ok  = v && legal(s, o);
        mul = (o == 8'h18 || o == 8'h19);
        ed  = (ok && !mul) ? alu_ref(o, a, b) : 32'd0;
        drive(v, s, o, a, b, w, wa);
        @(posedge clk); #1;
        chk("wb_valid", wb_valid, ok);
        chk("wb_we", wb_we, ok && w && !mul);
        chk("wb_wdata", wb_wdata, ed);
        if (ok) chk("wb_waddr", wb_waddr, wa);
        if (ok && mul) begin
            if (o == 8'h18) p = 64'(longint'(int'(a)) * longint'(int'(b)));
            else            p = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic w, input logic [4:0] wa);
        logic [31:0] ma, mb, q, r;
        int n, exp_n;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; exp_n = 1;
        end else begin
            ma = (sgn && a[31]) ? 32'd0 - a : a;
            mb = (sgn && b[31]) ? 32'd0 - b : b;
            q = ma / mb;
            r = ma % mb;
            if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
            if (sgn && a[31]) r = 32'd0 - r;
            exp_n = 33;
        end
        drive(1'b1, 3'd4, sgn ? 8'h1A : 8'h1B, a, b, w, wa);
        #1;
        n = 0;
        while (stall_req && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", n, exp_n);
        @(posedge clk); #1;
        chk("div_wb_valid", wb_valid, 1'b1);
        chk("div_wb_we", wb_we, 1'b0);
        chk("div_lo", lo, q);
        chk("div_hi", hi, r);
        m_hi = r;
        m_lo = q;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tbl[0]  = '{1, 3'd1, 8'h25, 32'h0000_1200, 32'h0000_0034, 1, 5'd5, 1, 1, 32'h0000_1234};
        tbl[1]  = '{1, 3'd1, 8'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 5'd6, 1, 1, 32'h00F0_00F0};
        tbl[2]  = '{1, 3'd1, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 5'd7, 1, 1, 32'hF0F0_0F0F};
        tbl[3]  = '{1, 3'd1, 8'h27, 32'h0000_0000, 32'h0000_FFFF, 1, 5'd8, 1, 1, 32'hFFFF_0000};
        tbl[4]  = '{1, 3'd2, 8'h03, 32'h0000_0004, 32'h8000_0000, 1, 5'd9, 1, 1, 32'hF800_0000};
        tbl[5]  = '{1, 3'd2, 8'h02, 32'h0000_0004, 32'h8000_0000, 1, 5'd10, 1, 1, 32'h0800_0000};
        tbl[6]  = '{1, 3'd2, 8'h7C, 32'h0000_001F, 32'h0000_0001, 1, 5'd11, 1, 1, 32'h8000_0000};
        tbl[7]  = '{1, 3'd4, 8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 1, 5'd12, 1, 1, 32'h0000_0000};
        tbl[8]  = '{1, 3'd4, 8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 1, 5'd13, 1, 1, 32'h0000_0001};
        tbl[9]  = '{1, 3'd4, 8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 1, 5'd14, 1, 1, 32'h0000_0001};
        tbl[10] = '{1, 3'd4, 8'h23, 32'h0000_0000, 32'h0000_0001, 1, 5'd15, 1, 1, 32'hFFFF_FFFF};
        tbl[11] = '{1, 3'd1, 8'h21, 32'h0000_0003, 32'h0000_0004, 1, 5'd16, 0, 0, 32'h0000_0000};
        tbl[12] = '{0, 3'd1, 8'h25, 32'h0000_0003, 32'h0000_0004, 1, 5'd17, 0, 0, 32'h0000_0000};
        tbl[13] = '{1, 3'd0, 8'h25, 32'h0000_0003, 32'h0000_0004, 1, 5'd18, 0, 0, 32'h0000_0000};
        tbl[14] = '{1, 3'd4, 8'h21, 32'h0000_0003, 32'h0000_0004, 0, 5'd19, 1, 0, 32'h0000_0007};

        // Reset with a divide presented: stall must stay low.
        drive(1'b1, 3'd4, 8'h1A, 32'd9, 32'd2, 1'b1, 5'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_waddr", wb_waddr, 5'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].wa);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), wb_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_we", i), wb_we, tbl[i].ewe);
            chk($sformatf("tbl%0d_wdata", i), wb_wdata, tbl[i].ed);
            if (tbl[i].ev) chk($sformatf("tbl%0d_waddr", i), wb_waddr, tbl[i].wa);
        end

        // MULT then MFLO back to back
        run_op(1, 3'd4, 8'h18, 32'hFFFF_FFFE, 32'd3, 1, 5'd2);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(1, 3'd3, 8'h12, 32'd0, 32'd0, 1, 5'd4);
        chk("mflo_wdata", wb_wdata, 32'hFFFF_FFFA);

        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 5'd3);
        chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(1, 3'd3, 8'h10, 32'd0, 32'd0, 1, 5'd4);

        do_div(1'b0, 32'd100, 32'd0, 1, 5'd3);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd100);

        // Reset during RUN aborts the divide
        run_op(1, 3'd4, 8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 5'd1);
        drive(1'b1, 3'd4, 8'h1A, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd3);
        #1;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_stall", stall_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_stall", stall_req, 1'b0);
        chk("abort_wb_valid", wb_valid, 1'b0);
        m_hi = '0;
        m_lo = '0;
        drive(1'b1, 3'd4, 8'h21, 32'd1, 32'd1, 1'b1, 5'd9);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", wb_valid, 1'b1);
        chk("post_rst_wdata", wb_wdata, 32'd2);
        chk("post_rst_waddr", wb_waddr, 5'd9);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        for (int k = 0; k < 300; k++) begin
            logic [2:0]  s;
            logic [7:0]  o;
            logic        v, w;
            logic [31:0] a, b;
            int          j;
            j = $urandom_range(0, 19);
            if (j < 17) begin
                s = CODES[j][10:8];
                o = CODES[j][7:0];
            end else begin
                s = 3'($urandom_range(0, 7));
                o = 8'($urandom);
            end
            v = ($urandom_range(0, 9) != 0);
            w = 1'($urandom);
            a = rnd32();
            b = rnd32();
            if (v && s == 3'd4 && (o == 8'h1A || o == 8'h1B))
                do_div(o == 8'h1A, a, b, w, 5'($urandom));
            else
                run_op(v, s, o, a, b, w, 5'($urandom));
        end

        drive(1'b0, 3'd0, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
